// File: rtl/fe_mul_seq.sv
// fe_mul_seq: sequences the 25 limb pairs of a 5x5 radix-2^51 product through
// the shared multiply-accumulate unit (MADDL/MADDH), accumulates the partial
// products into ten 64-bit columns and streams them out over valid/ready.
module fe_mul_seq #(
    parameter int MUL_LAT = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [319:0] in_a,
    input  logic [319:0] in_b,
    output logic         busy,
    output logic         mul_req_valid,
    output logic         mul_req_dw,
    output logic [5:0]   mul_req_fn,
    output logic [4:0]   mul_req_tag,
    output logic [63:0]  mul_in1,
    output logic [63:0]  mul_in2,
    output logic [63:0]  mul_in3,
    input  logic [63:0]  mul_resp_data,
    input  logic [4:0]   mul_resp_tag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_idx,
    output logic [63:0]  out_data,
    output logic         out_last
);

    localparam int NCOL = 10;
    localparam logic [5:0] FN_MADDL = 6'd50;
    localparam logic [5:0] FN_MADDH = 6'd51;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [319:0]       a_q, b_q;
    logic [2:0]         i_q, i_d;
    logic [2:0]         j_q, j_d;
    logic               hi_q, hi_d;
    logic [3:0]         idx_q, idx_d;
    logic [MUL_LAT-1:0] sr_q, sr_d;
    logic [63:0]        col_q [NCOL];
    logic [63:0]        col_d [NCOL];
    logic               load;
    logic               issue;
    logic               last_op;
    logic               tail;

    assign issue   = (state_q == S_ISSUE);
    // The MADDH half of pair (4,4) is the 50th and final request.
    assign last_op = (i_q == 3'd4) && (j_q == 3'd4) && hi_q;
    // Tail of the strobe shift register: this cycle's response is a real result.
    assign tail    = sr_q[MUL_LAT-1];

    // Next state, pair counters and output beat index.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        hi_d    = hi_q;
        idx_d   = idx_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    i_d     = 3'd0;
                    j_d     = 3'd0;
                    hi_d    = 1'b0;
                    idx_d   = 4'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_op) begin
                    state_d = S_DRAIN;
                end else begin
                    hi_d = ~hi_q;
                    if (hi_q) begin
                        if (j_q == 3'd4) begin
                            j_d = 3'd0;
                            i_d = i_q + 3'd1;
                        end else begin
                            j_d = j_q + 3'd1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Leave once the final in-flight result is accumulated this cycle.
                if (sr_d == '0) state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (idx_q == 4'd9) begin
                        idx_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Issue-strobe shift register and column accumulation of returning results.
    always_comb begin
        sr_d = (sr_q << 1) | MUL_LAT'(issue);
        for (int k = 0; k < NCOL; k++) begin
            col_d[k] = load ? 64'd0 : col_q[k];
            if (!load && tail && (mul_resp_tag == 5'(k))) begin
                col_d[k] = col_q[k] + mul_resp_data;
            end
        end
    end

    // State, counters, operand latches and column registers.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= 3'd0;
            j_q     <= 3'd0;
            hi_q    <= 1'b0;
            idx_q   <= 4'd0;
            sr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            // NOTE: the column file is only ten registers, and a reset mid-product
            // must leave nothing stale behind, so it is reset like any other state.
            for (int k = 0; k < NCOL; k++) col_q[k] <= 64'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            hi_q    <= hi_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            if (load) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            for (int k = 0; k < NCOL; k++) col_q[k] <= col_d[k];
        end
    end

    // Request port and output beat, both decoded from the current state.
    always_comb begin
        busy          = (state_q != S_IDLE);
        mul_req_valid = issue;
        mul_req_dw    = 1'b1;
        mul_in3       = 64'd0;
        mul_req_fn    = 6'd0;
        mul_req_tag   = 5'd0;
        mul_in1       = 64'd0;
        mul_in2       = 64'd0;
        if (issue) begin
            mul_req_fn  = hi_q ? FN_MADDH : FN_MADDL;
            mul_req_tag = 5'(i_q) + 5'(j_q) + 5'(hi_q);
            mul_in1     = a_q[{i_q, 6'd0} +: 64];
            mul_in2     = b_q[{j_q, 6'd0} +: 64];
        end
        out_valid = (state_q == S_OUT);
        out_idx   = idx_q;
        out_last  = out_valid && (idx_q == 4'd9);
        out_data  = 64'd0;
        if (out_valid) begin
            for (int k = 0; k < NCOL; k++) begin
                if (idx_q == 4'(k)) out_data = col_q[k];
            end
        end
    end

endmodule

// File: tb/tb_fe_mul_seq.sv
// tb_fe_mul_seq: table-driven check of fe_mul_seq against hand-computed column
// sums, with a behavioural two-stage MADDL/MADDH multiplier in the loop.
module tb_fe_mul_seq;

    localparam logic [63:0] M51 = 64'h0007_FFFF_FFFF_FFFF;   // 2^51-1
    localparam logic [63:0] M54 = 64'h003F_FFFF_FFFF_FFFF;   // 2^54-1
    localparam logic [63:0] H54 = 64'h01FF_FFFF_FFFF_FFF0;   // hi of (2^54-1)^2
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [319:0] in_a = '0;
    logic [319:0] in_b = '0;
    logic         busy;
    logic         mul_req_valid;
    logic         mul_req_dw;
    logic [5:0]   mul_req_fn;
    logic [4:0]   mul_req_tag;
    logic [63:0]  mul_in1, mul_in2, mul_in3;
    logic [63:0]  mul_resp_data;
    logic [4:0]   mul_resp_tag;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [3:0]   out_idx;
    logic [63:0]  out_data;
    logic         out_last;

    fe_mul_seq #(.MUL_LAT(2)) dut (
        .clock(clock), .reset(reset), .start(start), .in_a(in_a), .in_b(in_b),
        .busy(busy), .mul_req_valid(mul_req_valid), .mul_req_dw(mul_req_dw),
        .mul_req_fn(mul_req_fn), .mul_req_tag(mul_req_tag), .mul_in1(mul_in1),
        .mul_in2(mul_in2), .mul_in3(mul_in3), .mul_resp_data(mul_resp_data),
        .mul_resp_tag(mul_resp_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .out_last(out_last)
    );

    always #5 clock = ~clock;

    // Behavioural multiplier: MADDL = lo51(in1*in2)+in3, MADDH = (in1*in2>>51)+in3.
    function automatic logic [63:0] mul_model(input logic [5:0] fn,
                                              input logic [63:0] x, y, z);
        logic [127:0] p;
        logic [127:0] sh;
        p  = {64'd0, x} * {64'd0, y};
        sh = p >> 51;
        if (fn == 6'd51) return sh[63:0] + z;
        return {13'd0, p[50:0]} + z;
    endfunction

    logic        v0 = 1'b0, v1 = 1'b0;
    logic [63:0] d0 = '0, d1 = '0;
    logic [4:0]  t0 = '0, t1 = '0;

    // Two-stage result pipeline; idle cycles present junk data so stray
    // accumulations show up in the columns.
    always @(posedge clock) begin
        v0 <= mul_req_valid;
        d0 <= mul_model(mul_req_fn, mul_in1, mul_in2, mul_in3);
        t0 <= mul_req_tag;
        v1 <= v0;
        d1 <= d0;
        t1 <= t0;
    end
    assign mul_resp_data = v1 ? d1 : JUNK;
    assign mul_resp_tag  = v1 ? t1 : 5'd3;

    // Request monitor: counts requests and flags protocol violations.
    int         req_total = 0;
    int         proto_err = 0;
    logic       prev_v = 1'b0;
    logic [5:0] prev_fn = '0;
    always @(posedge clock) begin
        prev_v  <= mul_req_valid;
        prev_fn <= mul_req_fn;
        if (mul_req_valid) begin
            req_total <= req_total + 1;
            if (mul_req_dw !== 1'b1 || mul_in3 !== 64'd0 || mul_req_tag > 5'd9 ||
                mul_req_fn !== ((prev_v && prev_fn == 6'd50) ? 6'd51 : 6'd50))
                proto_err <= proto_err + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [319:0] a;
        logic [319:0] b;
        logic [639:0] cols;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [319:0] limbs(input logic [63:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [639:0] cols(input logic [63:0] c0, c1, c2, c3, c4,
                                          c5, c6, c7, c8, c9);
        return {c9, c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      64'(busy),          64'd0);
        check({tag, "_req_valid"}, 64'(mul_req_valid), 64'd0);
        check({tag, "_req_dw"},    64'(mul_req_dw),    64'd1);
        check({tag, "_req_fn"},    64'(mul_req_fn),    64'd0);
        check({tag, "_req_tag"},   64'(mul_req_tag),   64'd0);
        check({tag, "_in1"},       mul_in1,            64'd0);
        check({tag, "_in2"},       mul_in2,            64'd0);
        check({tag, "_in3"},       mul_in3,            64'd0);
        check({tag, "_out_valid"}, 64'(out_valid),     64'd0);
        check({tag, "_out_idx"},   64'(out_idx),       64'd0);
        check({tag, "_out_data"},  out_data,           64'd0);
        check({tag, "_out_last"},  64'(out_last),      64'd0);
    endtask

    // Runs one product starting in the current cycle. bp: random back-pressure
    // with a 5-cycle stall at beat 4. poke: extra start pulses in ISSUE and OUT,
    // including one coinciding with the final beat. exp_first > 0 checks the
    // cycle of the first out_valid (start sampled at edge 0).
    task automatic run_product(input int vi, input bit bp, input bit poke, input int exp_first);
        logic [63:0] got [10];
        int          n, first, beat, stall_left, req_base, err_base;
        bit          done, stalled, held;
        logic [3:0]  held_idx;
        logic [63:0] held_data;
        string       pfx;
        pfx        = $sformatf("v%0d", vi);
        in_a       = vecs[vi].a;
        in_b       = vecs[vi].b;
        req_base   = req_total;
        err_base   = proto_err;
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
        n          = 1;
        first      = -1;
        beat       = 0;
        stall_left = 0;
        done       = 1'b0;
        stalled    = 1'b0;
        held       = 1'b0;
        held_idx   = '0;
        held_data  = '0;
        for (int k = 0; k < 10; k++) got[k] = '0;
        while (!done && n < 300) begin
            if (out_valid && first < 0) first = n;
            if (!bp) out_ready = 1'b1;
            else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (!stalled && out_valid && out_idx == 4'd4) begin
                stalled    = 1'b1;
                stall_left = 4;
                out_ready  = 1'b0;
            end else out_ready = 1'($urandom_range(0, 1));
            if (held) begin
                check({pfx, "_stall_valid"}, 64'(out_valid), 64'd1);
                check({pfx, "_stall_idx"},   64'(out_idx),   64'(held_idx));
                check({pfx, "_stall_data"},  out_data,       held_data);
            end
            held = 1'b0;
            if (out_valid) begin
                check({pfx, "_last"}, 64'(out_last), 64'(out_idx == 4'd9));
                if (out_ready) begin
                    check({pfx, "_beat_idx"}, 64'(out_idx), 64'(beat));
                    if (beat < 10) got[beat] = out_data;
                    beat++;
                    if (out_idx == 4'd9) done = 1'b1;
                end else begin
                    held      = 1'b1;
                    held_idx  = out_idx;
                    held_data = out_data;
                end
            end
            start = poke && ((n == 20) ||
                    (out_valid && out_ready && (out_idx == 4'd2 || out_idx == 4'd9)));
            @(negedge clock);
            n++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check({pfx, "_completed"}, 64'(done), 64'd1);
        check({pfx, "_beats"},     64'(beat), 64'd10);
        check({pfx, "_post_busy"}, 64'(busy), 64'd0);
        check({pfx, "_post_valid"}, 64'(out_valid), 64'd0);
        check({pfx, "_req_count"}, 64'(req_total - req_base), 64'd50);
        check({pfx, "_req_proto"}, 64'(proto_err - err_base), 64'd0);
        if (exp_first > 0) check({pfx, "_first_valid_cycle"}, 64'(first), 64'(exp_first));
        for (int k = 0; k < 10; k++)
            check($sformatf("%s_col%0d", pfx, k), got[k], vecs[vi].cols[64*k +: 64]);
    endtask

    initial begin
        int rb;
        // All limbs 1: columns count the pairs per column.
        vecs[0].a    = limbs(1, 1, 1, 1, 1);
        vecs[0].b    = limbs(1, 1, 1, 1, 1);
        vecs[0].cols = cols(1, 2, 3, 4, 5, 4, 3, 2, 1, 0);
        // a0 = b0 = 2^51-1: lo = 1, hi = 2^51-2.
        vecs[1].a    = limbs(M51, 0, 0, 0, 0);
        vecs[1].b    = limbs(M51, 0, 0, 0, 0);
        vecs[1].cols = cols(1, 64'h0007_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, 0);
        // All limbs 2^54-1: every product has lo = 1, hi = 2^57-16.
        vecs[2].a    = limbs(M54, M54, M54, M54, M54);
        vecs[2].b    = limbs(M54, M54, M54, M54, M54);
        vecs[2].cols = cols(64'd1, 64'd2 + H54, 64'd3 + 64'd2*H54, 64'd4 + 64'd3*H54,
                            64'd5 + 64'd4*H54, 64'd4 + 64'd5*H54, 64'd3 + 64'd4*H54,
                            64'd2 + 64'd3*H54, 64'd1 + 64'd2*H54, H54);
        // a = 1..5, b1 = 1: column i+1 gets a[i].
        vecs[3].a    = limbs(1, 2, 3, 4, 5);
        vecs[3].b    = limbs(0, 1, 0, 0, 0);
        vecs[3].cols = cols(0, 1, 2, 3, 4, 5, 0, 0, 0, 0);
        // a0 = 2^54-1, b1 = 2^53+3: lo = 2^51-3 in col1, hi = 2^56+19 in col2.
        vecs[4].a    = limbs(M54, 0, 0, 0, 0);
        vecs[4].b    = limbs(0, 64'h0020_0000_0000_0003, 0, 0, 0);
        vecs[4].cols = cols(0, 64'h0007_FFFF_FFFF_FFFD, 64'h0100_0000_0000_0013,
                            0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("idle");

        run_product(0, 1'b0, 1'b0, 53);
        run_product(1, 1'b0, 1'b0, 0);
        run_product(2, 1'b1, 1'b0, 0);
        run_product(3, 1'b0, 1'b1, 0);
        // Starts in the cycle right after the previous final beat.
        run_product(4, 1'b0, 1'b0, 0);

        // Abort a max-limb product with reset in cycle 30, then rerun all-ones.
        @(negedge clock);
        in_a  = vecs[2].a;
        in_b  = vecs[2].b;
        rb    = req_total;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (29) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_idle_outputs("abort");
        check("abort_req_count", 64'(req_total - rb), 64'd30);
        reset = 1'b0;
        run_product(0, 1'b0, 1'b0, 53);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
